// File: rtl/saturn_bus_prog_queue_pkg.sv
// Shared Saturn bus definitions: BUSCMD codes, programming-queue entry layout and FSM encodings.
// Used by saturn_bus_prog_queue and its arbiter (SATURN_BUS_PROG_RR_ARB_EN selects round-robin).
package saturn_bus_prog_queue_pkg;

   typedef enum logic [3:0] {
      BUSCMD_NOP         = 4'h0,
      BUSCMD_ID          = 4'h1,
      BUSCMD_PC_READ     = 4'h2,
      BUSCMD_DP_READ     = 4'h3,
      BUSCMD_PC_WRITE    = 4'h4,
      BUSCMD_DP_WRITE    = 4'h5,
      BUSCMD_LOAD_PC     = 4'h6,
      BUSCMD_LOAD_DP     = 4'h7,
      BUSCMD_CONFIGURE   = 4'h8,
      BUSCMD_UNCONFIGURE = 4'h9,
      BUSCMD_POLL        = 4'hA,
      BUSCMD_BUS_RESET   = 4'hC,
      BUSCMD_SHUTDOWN    = 4'hD,
      BUSCMD_RESET       = 4'hF
   } buscmd_e;

   // Queue entry is {is_cmd, nibble}
   localparam int ENTRY_W      = 5;
   localparam int CMD_FLAG_BIT = 4;
   typedef logic [ENTRY_W-1:0] entry_t;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_CMD  = 2'd1;
   localparam logic [1:0] ST_ADDR = 2'd2;

   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/saturn_bus_prog_arbiter.sv
// Channel arbiter for the bus programming queue: one-hot grant from the request vector.
// Round-robin after the last grant with SATURN_BUS_PROG_RR_ARB_EN, else fixed lowest-index priority.
module saturn_bus_prog_arbiter
#(
   parameter int CHANNELS = 3
)
(
   input  logic [CHANNELS-1:0]                                        i_req,
   input  logic [saturn_bus_prog_queue_pkg::idx_width(CHANNELS)-1:0]  i_last_grant,
   output logic [CHANNELS-1:0]                                        o_grant
);
   import saturn_bus_prog_queue_pkg::*;

   logic found;

`ifdef SATURN_BUS_PROG_RR_ARB_EN
   // Search starts at the channel just above the last one served, wrapping around
   always_comb begin
      o_grant = '0;
      found   = 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
         if (!found && i_req[(int'(i_last_grant) + 1 + i) % CHANNELS]) begin
            o_grant[(int'(i_last_grant) + 1 + i) % CHANNELS] = 1'b1;
            found = 1'b1;
         end
      end
   end
`else
   logic unused_last_grant;
   assign unused_last_grant = ^i_last_grant;

   always_comb begin
      o_grant = '0;
      found   = 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
         if (!found && i_req[i]) begin
            o_grant[i] = 1'b1;
            found = 1'b1;
         end
      end
   end
`endif

endmodule

// File: rtl/saturn_bus_prog_queue.sv
// Saturn bus programming queue: serialises per-channel {command, address nibbles} into a show-ahead FIFO.
// Arbitration mode is chosen by SATURN_BUS_PROG_RR_ARB_EN in saturn_bus_prog_arbiter.
module saturn_bus_prog_queue
#(
   parameter int ADDR_NIBBLES = 5,
   parameter int DEPTH        = 32,
   parameter int CHANNELS     = 3
)
(
   input  logic                                 i_clk,
   input  logic                                 i_reset_n,
   input  logic                                 i_clk_en,
   input  logic [CHANNELS-1:0]                  i_req,
   input  logic [4*CHANNELS-1:0]                i_cmd,
   input  logic [4*ADDR_NIBBLES*CHANNELS-1:0]   i_addr,
   input  logic                                 i_flush,
   output logic [CHANNELS-1:0]                  o_ack,
   output logic [4:0]                           o_data,
   output logic                                 o_valid,
   input  logic                                 i_ready,
   output logic [$clog2(DEPTH):0]               o_level,
   output logic                                 o_busy
);
   import saturn_bus_prog_queue_pkg::*;

   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = PTR_W + 1;
   localparam int CH_W  = idx_width(CHANNELS);
   localparam int NIB_W = idx_width(ADDR_NIBBLES);
   localparam int AW    = 4 * ADDR_NIBBLES;

   logic [1:0]          state_q, state_d;
   logic [CH_W-1:0]     grant_q, grant_d;
   logic [3:0]          cmd_q, cmd_d;
   logic [AW-1:0]       addr_q, addr_d;
   logic [NIB_W-1:0]    ptr_q, ptr_d;
   logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0]    level_q, level_d;
   logic [CHANNELS-1:0] ack_q, ack_d;
   logic [CH_W-1:0]     arb_ptr_q, arb_ptr_d;
   entry_t              mem_q [DEPTH];

   logic [CHANNELS-1:0] arb_grant;
   logic [CH_W-1:0]     grant_idx;
   logic [CH_W-1:0]     last_grant;
   logic                space_ok;
   logic                push;
   logic                pop;
   entry_t              push_data;

   // arb_ptr_q holds the next search start; the arbiter wants the channel served before it
   assign last_grant = (arb_ptr_q == '0) ? CH_W'(CHANNELS - 1) : arb_ptr_q - 1'b1;

   saturn_bus_prog_arbiter #(.CHANNELS(CHANNELS)) u_arbiter (
      .i_req        (i_req),
      .i_last_grant (last_grant),
      .o_grant      (arb_grant)
   );

   always_comb begin
      grant_idx = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         if (arb_grant[i]) grant_idx = CH_W'(i);
      end
   end

   // A whole sequence must fit before it starts, so it can never overflow midway
   assign space_ok = (LVL_W'(DEPTH) - level_q) >= LVL_W'(ADDR_NIBBLES + 1);

   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      cmd_d     = cmd_q;
      addr_d    = addr_q;
      ptr_d     = ptr_q;
      ack_d     = '0;
      arb_ptr_d = arb_ptr_q;
      push      = 1'b0;
      push_data = '0;
      case (state_q)
         ST_IDLE: begin
            if (|i_req && space_ok) begin
               grant_d = grant_idx;
               cmd_d   = i_cmd[grant_idx*4 +: 4];
               addr_d  = i_addr[grant_idx*AW +: AW];
               state_d = ST_CMD;
            end
         end
         ST_CMD: begin
            push      = 1'b1;
            push_data = {1'b1, cmd_q};
            ptr_d     = '0;
            state_d   = ST_ADDR;
         end
         ST_ADDR: begin
            push      = 1'b1;
            push_data = {1'b0, addr_q[ptr_q*4 +: 4]};
            if (ptr_q == NIB_W'(ADDR_NIBBLES - 1)) begin
               ack_d[grant_q] = 1'b1;
               arb_ptr_d      = (grant_q == CH_W'(CHANNELS - 1)) ? '0 : grant_q + 1'b1;
               state_d        = ST_IDLE;
            end else begin
               ptr_d = ptr_q + 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      pop      = (level_q != '0) && i_ready;
      wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
      case ({push, pop})
         2'b10:   level_d = level_q + 1'b1;
         2'b01:   level_d = level_q - 1'b1;
         default: level_d = level_q;
      endcase

      // Flush overrides everything; the arbiter pointer is untouched so the aborted channel is served again
      if (i_flush) begin
         state_d  = ST_IDLE;
         ack_d    = '0;
         push     = 1'b0;
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         level_d  = '0;
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         state_q   <= ST_IDLE;
         grant_q   <= '0;
         cmd_q     <= '0;
         addr_q    <= '0;
         ptr_q     <= '0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         level_q   <= '0;
         ack_q     <= '0;
         arb_ptr_q <= '0;
      end else if (i_clk_en) begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         cmd_q     <= cmd_d;
         addr_q    <= addr_d;
         ptr_q     <= ptr_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         level_q   <= level_d;
         ack_q     <= ack_d;
         arb_ptr_q <= arb_ptr_d;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset_n && i_clk_en && push) mem_q[wr_ptr_q] <= push_data;
   end

   assign o_ack   = ack_q;
   assign o_data  = mem_q[rd_ptr_q];
   assign o_valid = (level_q != '0);
   assign o_level = level_q;
   assign o_busy  = (state_q != ST_IDLE);

endmodule
